// File: rtl/aclk_controller.sv
// Keypad-entry sequencer for the alarm clock: shifts digits, drives the display mux,
// and commits the entry as alarm or current time. Define ACLK_CTRL_TIMEOUT_EN for the inactivity timeout.
module aclk_controller #(
  parameter int         TIMEOUT_SEC = 10,
  parameter logic [3:0] NOKEY       = 4'hA
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       show_new_time,
  output logic       show_a,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAIT         = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   key_down;
  logic   timeout;

  assign key_down = (key != NOKEY);

`ifdef ACLK_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_SEC + 1);

  logic [CW-1:0] count;

  assign timeout = one_second && (count == CW'(TIMEOUT_SEC - 1));

  // Counts idle seconds only between key presses; a fresh key restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!(state inside {KEY_WAIT, KEY_ENTRY}) || state_nxt == KEY_STORED) begin
      count <= '0;
    end else if (one_second && count != CW'(TIMEOUT_SEC)) begin
      count <= count + 1'b1;
    end
  end
`else
  logic unused_ok;

  assign timeout   = 1'b0;
  assign unused_ok = one_second & (TIMEOUT_SEC > 0);
`endif

  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)  state_nxt = SHOW_ALARM;
        else if (key_down) state_nxt = KEY_STORED;
      end
      KEY_STORED: state_nxt = KEY_WAIT;
      KEY_WAIT: begin
        if (!key_down)    state_nxt = KEY_ENTRY;
        else if (timeout) state_nxt = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)     state_nxt = SET_ALARM_TIME;
        else if (time_button) state_nxt = SET_CURRENT_TIME;
        else if (key_down)    state_nxt = KEY_STORED;
        else if (timeout)     state_nxt = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_nxt = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_nxt = SHOW_TIME;
      SET_CURRENT_TIME: state_nxt = SHOW_TIME;
      default:          state_nxt = SHOW_TIME;
    endcase
  end

  // Outputs decode the next state so they line up exactly with state occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SHOW_TIME;
      shift         <= 1'b0;
      show_new_time <= 1'b0;
      show_a        <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state         <= state_nxt;
      shift         <= (state_nxt == KEY_STORED);
      show_new_time <= (state_nxt inside {KEY_STORED, KEY_WAIT, KEY_ENTRY});
      show_a        <= (state_nxt == SHOW_ALARM);
      load_new_a    <= (state_nxt == SET_ALARM_TIME);
      load_new_c    <= (state_nxt == SET_CURRENT_TIME);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_aclk_controller.sv
// Self-checking bench for aclk_controller: directed scenarios plus random keypad traffic
// compared against an entry-session model of the controller.
module tb_aclk_controller;

  localparam int         TIMEOUT_SEC = 10;
  localparam logic [3:0] NOKEY       = 4'hA;
`ifdef ACLK_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       shift;
  logic       show_new_time;
  logic       show_a;
  logic       load_new_a;
  logic       load_new_c;
  logic [2:0] state_o;

  aclk_controller #(.TIMEOUT_SEC(TIMEOUT_SEC), .NOKEY(NOKEY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .one_second   (one_second),
    .key          (key),
    .alarm_button (alarm_button),
    .time_button  (time_button),
    .shift        (shift),
    .show_new_time(show_new_time),
    .show_a       (show_a),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Model: what the user is doing, not how the FSM encodes it.
  typedef enum {M_IDLE, M_ALARM, M_ENTRY, M_COMMIT_A, M_COMMIT_C} mode_t;
  typedef enum {P_STORED, P_HELD, P_READY} phase_t;

  mode_t  m_mode;
  phase_t m_phase;
  int     m_secs;

  int n_pass  = 0;
  int n_total = 0;
  int shifts_seen;
  int loads_a_seen;
  int loads_c_seen;

  function automatic void model_reset();
    m_mode  = M_IDLE;
    m_phase = P_STORED;
    m_secs  = 0;
  endfunction

  function automatic void model_step(input logic [3:0] k, input logic ab, input logic tbn,
                                     input logic os);
    bit pressed;
    bit waiting;
    bit to;
    pressed = (k != NOKEY);
    waiting = (m_mode == M_ENTRY) && (m_phase != P_STORED);
    to      = TO_EN && waiting && os && (m_secs == TIMEOUT_SEC - 1);
    if (waiting && os && m_secs < TIMEOUT_SEC) m_secs++;
    case (m_mode)
      M_IDLE: begin
        if (ab) m_mode = M_ALARM;
        else if (pressed) begin
          m_mode  = M_ENTRY;
          m_phase = P_STORED;
          m_secs  = 0;
        end
      end
      M_ALARM:    if (!ab) m_mode = M_IDLE;
      M_COMMIT_A: m_mode = M_IDLE;
      M_COMMIT_C: m_mode = M_IDLE;
      M_ENTRY: begin
        case (m_phase)
          P_STORED: m_phase = P_HELD;
          P_HELD: begin
            if (!pressed) m_phase = P_READY;
            else if (to)  m_mode  = M_IDLE;
          end
          P_READY: begin
            if (ab)       m_mode = M_COMMIT_A;
            else if (tbn) m_mode = M_COMMIT_C;
            else if (pressed) begin
              m_phase = P_STORED;
              m_secs  = 0;
            end else if (to) m_mode = M_IDLE;
          end
          default: m_phase = P_STORED;
        endcase
      end
      default: m_mode = M_IDLE;
    endcase
    if (m_mode != M_ENTRY) m_secs = 0;
  endfunction

  function automatic logic [2:0] exp_state();
    case (m_mode)
      M_ALARM:    return 3'd4;
      M_COMMIT_A: return 3'd5;
      M_COMMIT_C: return 3'd6;
      M_ENTRY:    return (m_phase == P_STORED) ? 3'd1 : (m_phase == P_HELD) ? 3'd2 : 3'd3;
      default:    return 3'd0;
    endcase
  endfunction

  // {shift, show_new_time, show_a, load_new_a, load_new_c}
  function automatic logic [4:0] exp_outs();
    return {m_mode == M_ENTRY && m_phase == P_STORED, m_mode == M_ENTRY,
            m_mode == M_ALARM, m_mode == M_COMMIT_A, m_mode == M_COMMIT_C};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic step(input logic [3:0] k, input logic ab, input logic tbn, input logic os,
                      input string tag);
    key          = k;
    alarm_button = ab;
    time_button  = tbn;
    one_second   = os;
    model_step(k, ab, tbn, os);
    @(posedge clk);
    #1;
    if (shift)      shifts_seen++;
    if (load_new_a) loads_a_seen++;
    if (load_new_c) loads_c_seen++;
    check({tag, ".state"}, 8'(state_o), 8'(exp_state()));
    check({tag, ".outs"},
          8'({shift, show_new_time, show_a, load_new_a, load_new_c}), 8'(exp_outs()));
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    key          = NOKEY;
    alarm_button = 1'b0;
    time_button  = 1'b0;
    one_second   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.state", 8'(state_o), 8'd0);
    check("reset.outs", 8'({shift, show_new_time, show_a, load_new_a, load_new_c}), 8'd0);
    rst_n = 1'b1;
  endtask

  task automatic clear_tallies();
    shifts_seen  = 0;
    loads_a_seen = 0;
    loads_c_seen = 0;
  endtask

  initial begin
    logic [3:0] digits [4];
    logic [3:0] rk;
    digits[0] = 4'd1; digits[1] = 4'd2; digits[2] = 4'd3; digits[3] = 4'd4;

    do_reset();

    // Held key shifts once; sequence 1,2,2,2 then 3 on release.
    clear_tallies();
    repeat (4) step(4'd5, 1'b0, 1'b0, 1'b0, "hold5");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "hold5.rel");
    check("hold5.shifts", 8'(shifts_seen), 8'd1);
    check("hold5.in_entry", 8'(state_o), 8'd3);

    // Type 1,2,3,4 then commit as current time.
    do_reset();
    clear_tallies();
    for (int i = 0; i < 4; i++) begin
      step(digits[i], 1'b0, 1'b0, 1'b0, "digit");
      step(NOKEY, 1'b0, 1'b0, 1'b0, "digit.rel");
      step(NOKEY, 1'b0, 1'b0, 1'b0, "digit.idle");
    end
    step(NOKEY, 1'b0, 1'b1, 1'b0, "commit_c");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "commit_c.after");
    check("commit_c.shifts", 8'(shifts_seen), 8'd4);
    check("commit_c.loads", 8'(loads_c_seen), 8'd1);
    check("commit_c.home", 8'(state_o), 8'd0);

    // Both buttons in KEY_ENTRY, together with a new key: alarm wins, key ignored.
    clear_tallies();
    step(4'd7, 1'b0, 1'b0, 1'b0, "both.key");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "both.rel");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "both.idle");
    step(4'd9, 1'b1, 1'b1, 1'b0, "both.press");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "both.after");
    check("both.load_a", 8'(loads_a_seen), 8'd1);
    check("both.load_c", 8'(loads_c_seen), 8'd0);
    check("both.shifts", 8'(shifts_seen), 8'd1);

    // Alarm display follows the held button.
    repeat (6) step(NOKEY, 1'b1, 1'b0, 1'b0, "alarm_hold");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "alarm_rel");
    check("alarm_rel.show_a", 8'(show_a), 8'd0);

    // Reset asserted mid-entry clears everything at once, no strobe.
    step(4'd2, 1'b0, 1'b0, 1'b0, "mid.key");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "mid.rel");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "mid.idle");
    clear_tallies();
    #2 rst_n = 1'b0;
    key = 4'd6; alarm_button = 1'b0; time_button = 1'b1;
    #1;
    check("mid.rst.state", 8'(state_o), 8'd0);
    check("mid.rst.outs", 8'({shift, show_new_time, show_a, load_new_a, load_new_c}), 8'd0);
    @(posedge clk);
    #1;
    check("mid.rst.hold", 8'({state_o, load_new_a, load_new_c, shift}), 8'd0);
    rst_n = 1'b1;
    model_reset();
    step(NOKEY, 1'b0, 1'b0, 1'b0, "mid.post");

    // Random keypad traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rk = ($urandom_range(0, 9) < 6) ? NOKEY : 4'($urandom_range(0, 9));
      step(rk, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) == 0), "rand");
    end

`ifdef ACLK_CTRL_TIMEOUT_EN
    // Key on the 9th second restarts the count; then 10 idle seconds abandon the entry.
    do_reset();
    clear_tallies();
    step(4'd3, 1'b0, 1'b0, 1'b0, "to.key");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "to.rel");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "to.idle");
    for (int s = 1; s <= 8; s++) step(NOKEY, 1'b0, 1'b0, 1'b1, "to.sec");
    step(4'd4, 1'b0, 1'b0, 1'b1, "to.sec9key");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "to.rel2");
    step(NOKEY, 1'b0, 1'b0, 1'b0, "to.idle2");
    for (int s = 1; s <= 9; s++) step(NOKEY, 1'b0, 1'b0, 1'b1, "to.sec2");
    check("to.still_entry", 8'(state_o), 8'd3);
    step(NOKEY, 1'b0, 1'b0, 1'b1, "to.sec10");
    check("to.exit", 8'(state_o), 8'd0);
    check("to.no_load", 8'(loads_a_seen + loads_c_seen), 8'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
